// File: rtl/psum_writeback.sv
// psum_writeback: final-pass consumer of PE column psums.
// Round-robin arbitration, requantization, ofmap SRAM writes.
`ifndef PSUM_DATA_SIZE
`define PSUM_DATA_SIZE 16
`endif

package psum_pkg;
  parameter int PSUM_DATA_SIZE = `PSUM_DATA_SIZE;

  typedef struct packed {
    logic                             valid;
    logic [1:0]                       filter_idx;
    logic signed [PSUM_DATA_SIZE-1:0] psum;
  } psum_packet_t;
endpackage

module psum_writeback
  import psum_pkg::*;
#(
  parameter int PSUM_W = PSUM_DATA_SIZE,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 6,
  parameter int ADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_wb,
  input  logic [CNT_W-1:0]         rows_in,
  input  logic [4:0]               shift_amt,
  input  logic                     relu_en,
  input  psum_packet_t [6:0]       psum_in,
  output logic [6:0]               wb_ack,
  input  logic                     mem_ready,
  output logic                     mem_wen,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [OUT_W-1:0]         mem_wdata,
  output logic                     busy,
  output logic                     done
);

  localparam int NCOL = 7;
  localparam int NFLT = 4;

  localparam logic signed [PSUM_W:0] U_MAX =
    (PSUM_W+1)'((1 << OUT_W) - 1);
  localparam logic signed [PSUM_W:0] S_MAX =
    (PSUM_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PSUM_W:0] S_MIN = ~S_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] rows_q;
  logic [4:0]       shift_q;
  logic             relu_q;

  logic [CNT_W-1:0] cnt_q [NCOL][NFLT];
  logic [2:0]       ptr_q;

  logic                     s1_v_q;
  logic signed [PSUM_W-1:0] s1_psum_q;
  logic [ADDR_W-1:0]        s1_addr_q;

  logic              advance;
  logic [NCOL-1:0]   elig;
  logic              grant_v;
  logic [2:0]        grant_col;
  logic [1:0]        g_flt;
  logic [PSUM_W-1:0] g_psum;
  logic [CNT_W-1:0]  g_cnt;
  logic              all_full;
  logic              start_ok;

  logic signed [PSUM_W:0] q_x;
  logic signed [PSUM_W:0] q_rnd;
  logic signed [PSUM_W:0] q_sh;
  logic [OUT_W-1:0]       q_out;

  function automatic logic [2:0] wrap(
    input logic [2:0] p,
    input int         k
  );
    logic [3:0] s;
    s = {1'b0, p} + 4'(k);
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0];
  endfunction

  assign advance  = !s1_v_q || mem_ready;
  assign start_ok = (state_q == S_IDLE) && start_wb;

  // Per-column eligibility: valid, under quota, room downstream.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCOL; i++) begin
      elig[i] = (state_q == S_RUN)
             && psum_in[i].valid
             && (cnt_q[i][psum_in[i].filter_idx] < rows_q)
             && advance;
    end
  end

  // Round-robin pick: first eligible column at or after ptr.
  always_comb begin
    grant_v   = 1'b0;
    grant_col = '0;
    for (int k = 0; k < NCOL; k++) begin
      if (!grant_v && elig[wrap(ptr_q, k)]) begin
        grant_v   = 1'b1;
        grant_col = wrap(ptr_q, k);
      end
    end
  end

  // Granted packet fields and ack vector.
  always_comb begin
    g_flt  = psum_in[grant_col].filter_idx;
    g_psum = psum_in[grant_col].psum;
    g_cnt  = cnt_q[grant_col][g_flt];
    wb_ack = '0;
    if (grant_v) wb_ack = NCOL'(1) << grant_col;
  end

  // Completion: every (column, filter) reached rows_q.
  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < NCOL; i++) begin
      for (int f = 0; f < NFLT; f++) begin
        if (cnt_q[i][f] != rows_q) all_full = 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_wb) state_d = S_RUN;
      S_RUN:  if (all_full && !s1_v_q) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and run parameters latched at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        rows_q  <= rows_in;
        shift_q <= shift_amt;
        relu_q  <= relu_en;
      end
    end
  end

  // Per-(column, filter) row counters; cleared on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOL; i++) begin
        for (int f = 0; f < NFLT; f++) begin
          cnt_q[i][f] <= '0;
        end
      end
    end else if (start_ok) begin
      for (int i = 0; i < NCOL; i++) begin
        for (int f = 0; f < NFLT; f++) begin
          cnt_q[i][f] <= '0;
        end
      end
    end else if (grant_v) begin
      cnt_q[grant_col][g_flt] <= g_cnt + CNT_W'(1);
    end
  end

  // Round-robin pointer moves past the granted column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (grant_v) begin
      ptr_q <= wrap(grant_col, 1);
    end
  end

  // Stage s1: granted psum and its ofmap address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_psum_q <= '0;
      s1_addr_q <= '0;
    end else if (grant_v) begin
      s1_v_q    <= 1'b1;
      s1_psum_q <= g_psum;
      s1_addr_q <= ADDR_W'({g_flt, grant_col, g_cnt});
    end else if (mem_ready) begin
      s1_v_q    <= 1'b0;
    end
  end

  // Requantize: relu, round half-up, shift, saturate.
  always_comb begin
    q_x = {s1_psum_q[PSUM_W-1], s1_psum_q};
    if (relu_q && s1_psum_q[PSUM_W-1]) q_x = '0;
    q_rnd = '0;
    if (shift_q != 5'd0) begin
      q_rnd = (PSUM_W+1)'(1) << (shift_q - 5'd1);
    end
    q_sh  = (q_x + q_rnd) >>> shift_q;
    q_out = q_sh[OUT_W-1:0];
    unique case (1'b1)
      relu_q && (q_sh > U_MAX):  q_out = '1;
      !relu_q && (q_sh > S_MAX): q_out = S_MAX[OUT_W-1:0];
      !relu_q && (q_sh < S_MIN): q_out = S_MIN[OUT_W-1:0];
      default: ;
    endcase
  end

  assign mem_wen   = s1_v_q;
  assign mem_addr  = s1_v_q ? s1_addr_q : '0;
  assign mem_wdata = s1_v_q ? q_out : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_psum_writeback.sv
// tb_psum_writeback: randomized PE-column traffic checked
// against a cycle model of arbitration and requantization.
module tb_psum_writeback;
  import psum_pkg::*;

  localparam int PW = PSUM_DATA_SIZE;

  typedef struct {
    int f;
    int p;
  } pkt_t;

  logic               clk;
  logic               rst_n;
  logic               start_wb;
  logic [5:0]         rows_in;
  logic [4:0]         shift_amt;
  logic               relu_en;
  psum_packet_t [6:0] psum_in;
  logic [6:0]         wb_ack;
  logic               mem_ready;
  logic               mem_wen;
  logic [10:0]        mem_addr;
  logic [7:0]         mem_wdata;
  logic               busy;
  logic               done;

  psum_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_wb  (start_wb),
    .rows_in   (rows_in),
    .shift_amt (shift_amt),
    .relu_en   (relu_en),
    .psum_in   (psum_in),
    .wb_ack    (wb_ack),
    .mem_ready (mem_ready),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int vecs;
  int errs;

  // reference model state
  int m_phase;
  int m_ptr;
  int m_rows;
  int m_shift;
  bit m_relu;
  int m_cnt [7][4];
  bit p_v;
  int p_addr;
  int p_data;

  // PE column sources
  pkt_t q [7][$];
  bit   dir_en;
  int   dir_psum [4];

  // observations of the DUT
  logic [7:0] wr_data [2048];
  bit         wr_seen [2048];
  int wr_cnt, done_cnt, dup_cnt;
  int last_wr_cyc, done_cyc;
  int ack_log [$];
  int ack_cnt [7];
  int stall_at_g;
  int stall_acks;

  function automatic int quant(input int p, input int sh, input bit relu);
    longint x;
    x = (relu && p < 0) ? 0 : longint'(p);
    if (sh > 0) x = x + (longint'(1) << (sh - 1));
    x = x >>> sh;
    if (relu) begin
      if (x > 255) x = 255;
    end else begin
      if (x > 127) x = 127;
      else if (x < -128) x = -128;
    end
    return int'(x);
  endfunction

  function automatic int rand_psum();
    int lo;
    int span;
    lo   = -(1 << (PW - 1));
    span = 1 << PW;
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(0, span - 1)) + lo;
    return int'($urandom_range(0, 1200)) - 600;
  endfunction

  task automatic reset_model();
    m_phase = 0;
    m_ptr   = 0;
    m_rows  = 0;
    m_shift = 0;
    m_relu  = 0;
    p_v     = 0;
    for (int c = 0; c < 7; c++)
      for (int f = 0; f < 4; f++) m_cnt[c][f] = 0;
  endtask

  task automatic build(input int rows, input bit shuf, input bit extra);
    pkt_t pk;
    pkt_t tmp;
    int j;
    for (int c = 0; c < 7; c++) begin
      q[c].delete();
      for (int f = 0; f < 4; f++) begin
        for (int r = 0; r < rows; r++) begin
          pk.f = f;
          pk.p = (dir_en && c == 0 && r == 0) ? dir_psum[f] : rand_psum();
          q[c].push_back(pk);
        end
      end
      if (shuf) begin
        for (int i = q[c].size() - 1; i > 0; i--) begin
          j = int'($urandom_range(0, i));
          tmp = q[c][i];
          q[c][i] = q[c][j];
          q[c][j] = tmp;
        end
      end
    end
    if (extra) begin
      pk.f = 2;
      pk.p = rand_psum();
      q[3].push_back(pk);
    end
  endtask

  // Compare one cycle, record DUT writes, then advance the model.
  task automatic model_step(input int cyc);
    int g;
    int c;
    int f;
    bit adv;
    bit fin_ok;
    logic [6:0] exp_ack;
    adv = !p_v || mem_ready;
    g = -1;
    for (int k = 0; k < 7; k++) begin
      c = (m_ptr + k) % 7;
      if (g < 0 && m_phase == 1 && psum_in[c].valid && adv
          && m_cnt[c][psum_in[c].filter_idx] < m_rows) g = c;
    end
    exp_ack = (g < 0) ? 7'd0 : 7'(1 << g);
    vecs++;
    if (wb_ack !== exp_ack) begin
      errs++;
      $display("FAIL wb_ack cyc=%0d got=%b want=%b", cyc, wb_ack, exp_ack);
    end
    vecs++;
    if (mem_wen !== p_v) begin
      errs++;
      $display("FAIL mem_wen cyc=%0d got=%b want=%b", cyc, mem_wen, p_v);
    end
    if (p_v) begin
      vecs++;
      if (mem_addr !== 11'(p_addr)) begin
        errs++;
        $display("FAIL mem_addr cyc=%0d got=%h want=%h", cyc, mem_addr, 11'(p_addr));
      end
      vecs++;
      if (mem_wdata !== 8'(p_data)) begin
        errs++;
        $display("FAIL mem_wdata cyc=%0d got=%h want=%h", cyc, mem_wdata, 8'(p_data));
      end
    end
    vecs++;
    if (busy !== (m_phase != 0)) begin
      errs++;
      $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, m_phase != 0);
    end
    vecs++;
    if (done !== (m_phase == 2)) begin
      errs++;
      $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, m_phase == 2);
    end
    if (mem_wen === 1'b1 && mem_ready) begin
      if (wr_seen[mem_addr]) dup_cnt++;
      wr_seen[mem_addr] = 1;
      wr_data[mem_addr] = mem_wdata;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    for (int i = 0; i < 7; i++) begin
      if (wb_ack[i] === 1'b1) begin
        ack_log.push_back(i);
        ack_cnt[i]++;
        if (stall_at_g >= 0 && cyc >= stall_at_g && cyc < stall_at_g + 5)
          stall_acks++;
      end
    end
    fin_ok = 1;
    for (int i = 0; i < 7; i++)
      for (int k = 0; k < 4; k++)
        if (m_cnt[i][k] != m_rows) fin_ok = 0;
    case (m_phase)
      0: if (start_wb) begin
        m_phase = 1;
        m_rows  = int'(rows_in);
        m_shift = int'(shift_amt);
        m_relu  = relu_en;
        for (int i = 0; i < 7; i++)
          for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      end
      1: if (fin_ok && !p_v) m_phase = 2;
      default: m_phase = 0;
    endcase
    if (g >= 0) begin
      f = int'(psum_in[g].filter_idx);
      p_v    = 1;
      p_addr = f * 512 + g * 64 + m_cnt[g][f];
      p_data = quant(q[g][0].p, m_shift, m_relu);
      m_cnt[g][f]++;
      m_ptr = (g + 1) % 7;
      void'(q[g].pop_front());
    end else if (mem_ready) begin
      p_v = 0;
    end
  endtask

  // One writeback pass: start, feed columns, run until done.
  task automatic run_op(input int rows, input int sh, input bit relu,
                        input int stall_at, input int vprob, input int rprob,
                        input int limit, input bit expect_done);
    int cyc;
    int post;
    for (int a = 0; a < 2048; a++) begin
      wr_seen[a] = 0;
      wr_data[a] = 8'h00;
    end
    for (int i = 0; i < 7; i++) ack_cnt[i] = 0;
    wr_cnt = 0; done_cnt = 0; dup_cnt = 0;
    last_wr_cyc = -1; done_cyc = -1;
    ack_log.delete();
    stall_at_g = stall_at;
    stall_acks = 0;
    cyc = 0;
    post = 0;
    while (post < 3 && cyc < limit) begin
      @(posedge clk);
      #1;
      start_wb  = (cyc == 0);
      rows_in   = 6'(rows);
      shift_amt = 5'(sh);
      relu_en   = relu;
      if (stall_at >= 0)
        mem_ready = !(cyc >= stall_at && cyc < stall_at + 5);
      else
        mem_ready = ($urandom_range(0, 99) < rprob);
      for (int c = 0; c < 7; c++) begin
        if (q[c].size() > 0) begin
          psum_in[c].valid      = ($urandom_range(0, 99) < vprob);
          psum_in[c].filter_idx = 2'(q[c][0].f);
          psum_in[c].psum       = PW'(q[c][0].p);
        end else begin
          psum_in[c] = '0;
        end
      end
      @(negedge clk);
      model_step(cyc);
      cyc++;
      if (done_cnt > 0) post++;
    end
    start_wb = 0;
    psum_in  = '0;
    if (expect_done) begin
      vecs++;
      if (done_cnt != 1) begin
        errs++;
        $display("FAIL done_count got=%0d want=1 (cycles=%0d)", done_cnt, cyc);
      end
      vecs++;
      if (wr_cnt != 28 * rows) begin
        errs++;
        $display("FAIL write_count got=%0d want=%0d", wr_cnt, 28 * rows);
      end
      vecs++;
      if (dup_cnt != 0) begin
        errs++;
        $display("FAIL duplicate_writes got=%0d want=0", dup_cnt);
      end
      vecs++;
      if (done_cyc <= last_wr_cyc) begin
        errs++;
        $display("FAIL done_after_writes done=%0d last_wr=%0d", done_cyc, last_wr_cyc);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    psum_in[0].valid = 1'b1;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (wb_ack !== 7'd0) begin errs++; $display("FAIL rst_wb_ack got=%b want=0", wb_ack); end
    vecs++; if (mem_wen !== 1'b0) begin errs++; $display("FAIL rst_mem_wen got=%b want=0", mem_wen); end
    vecs++; if (mem_addr !== 11'd0) begin errs++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    vecs++; if (mem_wdata !== 8'd0) begin errs++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b want=0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b want=0", done); end
    psum_in = '0;
    reset_model();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_rotation();
    build(1, 0, 0);
    run_op(1, 0, 0, -1, 100, 100, 400, 1);
    vecs++;
    if (ack_log.size() != 28) begin
      errs++;
      $display("FAIL rotation_acks got=%0d want=28", ack_log.size());
    end
    for (int k = 0; k < 28 && k < ack_log.size(); k++) begin
      vecs++;
      if (ack_log[k] != k % 7) begin
        errs++;
        $display("FAIL rotation_order idx=%0d got=%0d want=%0d", k, ack_log[k], k % 7);
      end
    end
  endtask

  task automatic test_relu_quant();
    dir_en = 1;
    dir_psum[0] = -40; dir_psum[1] = 23; dir_psum[2] = 5000; dir_psum[3] = 0;
    build(1, 0, 0);
    dir_en = 0;
    run_op(1, 4, 1, -1, 100, 100, 400, 1);
    vecs++;
    if (!(wr_seen[0] && wr_data[0] === 8'd0)) begin
      errs++; $display("FAIL relu_neg got=%h want=00", wr_data[0]);
    end
    vecs++;
    if (!(wr_seen[512] && wr_data[512] === 8'd1)) begin
      errs++; $display("FAIL relu_round got=%h want=01", wr_data[512]);
    end
    vecs++;
    if (!(wr_seen[1024] && wr_data[1024] === 8'd255)) begin
      errs++; $display("FAIL relu_sat got=%h want=ff", wr_data[1024]);
    end
  endtask

  task automatic test_signed_quant();
    dir_en = 1;
    dir_psum[0] = -200; dir_psum[1] = 127; dir_psum[2] = 128; dir_psum[3] = -128;
    build(1, 1, 0);
    run_op(1, 0, 0, -1, 100, 100, 400, 1);
    vecs++;
    if (!(wr_seen[0] && wr_data[0] === 8'h80)) begin
      errs++; $display("FAIL signed_sat_lo got=%h want=80", wr_data[0]);
    end
    vecs++;
    if (!(wr_seen[512] && wr_data[512] === 8'h7f)) begin
      errs++; $display("FAIL signed_pass got=%h want=7f", wr_data[512]);
    end
    dir_psum[0] = -1;
    build(1, 1, 0);
    dir_en = 0;
    run_op(1, 1, 0, -1, 100, 100, 400, 1);
    vecs++;
    if (!(wr_seen[0] && wr_data[0] === 8'h00)) begin
      errs++; $display("FAIL signed_half_up got=%h want=00", wr_data[0]);
    end
  endtask

  task automatic test_backpressure();
    build(2, 1, 0);
    run_op(2, 3, 0, 12, 100, 100, 400, 1);
    vecs++;
    if (stall_acks != 0) begin
      errs++; $display("FAIL stall_acks got=%0d want=0", stall_acks);
    end
  endtask

  task automatic test_over_quota();
    build(2, 1, 1);
    run_op(2, 5, 1, -1, 90, 85, 600, 1);
    for (int c = 0; c < 7; c++) begin
      vecs++;
      if (ack_cnt[c] != 8) begin
        errs++; $display("FAIL quota_acks col=%0d got=%0d want=8", c, ack_cnt[c]);
      end
    end
  endtask

  task automatic test_rows_zero();
    build(0, 0, 0);
    run_op(0, 0, 0, -1, 100, 100, 50, 1);
    vecs++;
    if (done_cyc != 2) begin
      errs++; $display("FAIL rows_zero_latency got=%0d want=2", done_cyc);
    end
  endtask

  task automatic test_reset_midrun();
    build(3, 1, 0);
    run_op(3, 2, 0, -1, 100, 100, 15, 0);
    #2 rst_n = 0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got=%b want=0", busy); end
    vecs++; if (mem_wen !== 1'b0) begin errs++; $display("FAIL midrst_wen got=%b want=0", mem_wen); end
    vecs++; if (wb_ack !== 7'd0) begin errs++; $display("FAIL midrst_ack got=%b want=0", wb_ack); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL midrst_done got=%b want=0", done); end
    reset_model();
    @(posedge clk);
    #2 rst_n = 1;
    build(2, 1, 0);
    run_op(2, 3, 1, -1, 80, 90, 600, 1);
  endtask

  task automatic test_random();
    int rows;
    int sh;
    bit relu;
    for (int it = 0; it < 3; it++) begin
      rows = int'($urandom_range(1, 4));
      sh   = int'($urandom_range(0, PW - 1));
      relu = 1'($urandom_range(0, 1));
      build(rows, 1, 0);
      run_op(rows, sh, relu, -1, 70, 70, 1500, 1);
    end
  endtask

  initial begin
    clk       = 0;
    rst_n     = 1;
    start_wb  = 0;
    rows_in   = '0;
    shift_amt = '0;
    relu_en   = 0;
    mem_ready = 0;
    psum_in   = '0;
    dir_en    = 0;
    vecs      = 0;
    errs      = 0;
    reset_model();
    test_reset();
    test_rotation();
    test_relu_quant();
    test_signed_quant();
    test_backpressure();
    test_over_quota();
    test_rows_zero();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
